fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the dual-clock `fifo` among `NUM_REQ` producers in the write clock domain. It grants one requester at a time and holds the grant for a burst of up to `MAX_BURST` words or until the requester flags `req_last`. It then rotates the grant round-robin. It drives `winc`/`wdata` into the FIFO and uses the FIFO `full` flag for back-pressure, so no word is ever presented while full.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, word width; must match the FIFO
- `MAX_BURST`, 4, maximum words per grant (1..16)
- `clk`  in  1  write-domain clock (same net as FIFO `wclk`)
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester word valid
- `req_last`  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept; a word transfers when valid and ready are both high
- `full`  in  1  FIFO full flag (write domain)
- `winc`  out  1  FIFO write strobe
- `wdata`  out  DATA_WIDTH  FIFO write data
- `gnt_id`  out  clog2(NUM_REQ)  current owner index
- `busy`  out  1  high while a grant is held
- `stall_cnt`  out  16  stall counter; present only with `FIFO_ARB_STALL_CNT_EN`

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - `req_ready`=0 and `winc`=0.
  - If any `req_valid` is high, the round-robin picker selects the first valid index at or after `rr_ptr`, cyclically.
  - Next state is BURST. `gnt_id` and `owner` are registered. `beat_cnt` is cleared.
- BURST:
  - `req_ready[owner] = ~full`. All other ready bits are 0.
  - `winc = req_valid[owner] & ~full`.
  - `wdata = req_data[owner]`, always driven, don't-care when `winc`=0.
- On each transfer:
  - If `req_last[owner]` or `beat_cnt == MAX_BURST-1`: next state IDLE, `rr_ptr <= (owner+1) mod NUM_REQ`.
  - Otherwise `beat_cnt` increments.
- Owner `req_valid` low during BURST: grant is held, no transfer, `beat_cnt` unchanged. The grant is released only by last or burst cap.
- `full` high during BURST: owner is stalled. No count or state change.
- `busy` = (state == BURST).
- Reset (asynchronous, any time, including mid-burst):
  - state IDLE; `rr_ptr`, `owner`, `gnt_id`, `beat_cnt`, `stall_cnt` = 0.
  - `winc`, `req_ready`, `busy` = 0 immediately.
  - A partially written burst is not recovered; the FIFO is reset in the same domain.
- `beat_cnt` width is clog2(MAX_BURST)+1. It never wraps because the cap forces release.

## Timing
- Arbitration costs one IDLE cycle. `req_valid` is sampled in cycle N, and the first possible transfer is in cycle N+1.
- After release there is one IDLE bubble before the next grant.
- Within a burst, one word per clock when `~full`.
- `winc` and `req_ready` are combinational from state registers, `full` and `req_valid[owner]`. There is no register between the accept and the FIFO strobe; the FIFO samples on the same `clk` edge.
- Peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle when all requesters stream.

## Configuration
- `FIFO_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` port and its register exist.
  - Increments every cycle in BURST with `req_valid[owner] & full`.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `fifo_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - the `clog2`-based ID-width and beat-counter-width constants;
  - the `STALL_W = 16` constant.
- One sub-module, `fifo_rr_pick`: combinational. Inputs are the `req_valid` vector and `rr_ptr`; outputs are `any_valid` and `pick_idx`. It is instantiated once in `fifo_wr_arbiter`.

## Test plan
- Reset mid-burst: hold rst_n=0 during BURST with owner 2 -> `winc`, `req_ready`, `busy` drop the same cycle. After release the first grant goes to the lowest valid index starting from 0.
- Single requester: req 1 streams 6 words, `req_last` never set, MAX_BURST=4, full=0 -> words 0..3 are written on 4 consecutive cycles. One idle cycle follows, then words 4..5 are written under a new grant to req 1.
- Round-robin fairness: all four requesters valid continuously, MAX_BURST=4 -> grants 0,1,2,3,0,... with 4 words each and one bubble between grants, i.e. 16 words written in 20 cycles.
- Early last: req 3 sends 2 words with `req_last` on word 2 while req 0 is also valid -> req 3 is released after 2 words and the next grant goes to req 0.
- Full back-pressure: owner valid, full held high for 5 cycles mid-burst -> `winc`=0 and `req_ready`=0 for those cycles, `beat_cnt` frozen, and with the macro defined `stall_cnt` = 5. When full drops, the burst resumes with no lost or duplicated word.
- Owner idle in BURST: owner drops `req_valid` for 3 cycles while req 1 is valid -> grant is held, req 1 sees ready=0, and the burst completes after the owner resumes.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// Optional stall counter is enabled by defining FIFO_ARB_STALL_CNT_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STALL_W       = 16;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter holds 0..MAX_BURST-1 with one spare bit of headroom.
    function automatic int beat_width(input int m);
        return $clog2(m) + 1;
    endfunction

    localparam int DEF_ID_W   = id_width(DEF_NUM_REQ);
    localparam int DEF_BEAT_W = beat_width(DEF_MAX_BURST);

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first valid index at or after the
// pointer, searched cyclically.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic               any_valid_o,
    output logic [ID_W-1:0]    pick_idx_o
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [ID_W-1:0]      offset_s;
    logic [ID_W:0]        sum_s;

    // Rotate so bit 0 is the pointer position, then take the lowest set offset.
    always_comb begin
        dbl_s       = {req_valid_i, req_valid_i} >> rr_ptr_i;
        rot_s       = dbl_s[NUM_REQ-1:0];
        any_valid_o = |req_valid_i;
        offset_s    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                offset_s = ID_W'(k);
            end else begin
                offset_s = offset_s;
            end
        end
        sum_s = {1'b0, rr_ptr_i} + {1'b0, offset_s};
        if (sum_s >= (ID_W + 1)'(NUM_REQ)) begin
            sum_s = sum_s - (ID_W + 1)'(NUM_REQ);
        end else begin
            sum_s = sum_s;
        end
        pick_idx_o = sum_s[ID_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STALL_CNT_EN to add the saturating full-stall counter port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = id_width(NUM_REQ),
    localparam int BEAT_W     = beat_width(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [ID_W-1:0]               gnt_id,
    output logic                          busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]            stall_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              any_valid_s;
    logic [ID_W-1:0]   pick_idx_s;
    logic              own_valid_s;
    logic              own_last_s;
    logic              xfer_s;
    logic              burst_end_s;
    logic [ID_W-1:0]   next_ptr_s;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .any_valid_o (any_valid_s),
        .pick_idx_o  (pick_idx_s)
    );

    assign own_valid_s = req_valid[owner_q];
    assign own_last_s  = req_last[owner_q];
    assign xfer_s      = (state_q == BURST) && own_valid_s && !full;
    assign burst_end_s = own_last_s || (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign next_ptr_s  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // Write-port handshake is combinational so the FIFO captures on the accept edge.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == BURST) begin
            req_ready[owner_q] = !full;
            winc               = own_valid_s && !full;
        end else begin
            req_ready = '0;
            winc      = 1'b0;
        end
    end

    // Next-state: grant on any valid, release only on last or burst cap.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    state_d    = BURST;
                    owner_d    = pick_idx_s;
                    gnt_id_d   = pick_idx_s;
                    beat_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (xfer_s && burst_end_s) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else if (xfer_s) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy   = (state_q == BURST);
    assign gnt_id = gnt_id_q;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q;

    // Counts cycles the owner had data but the FIFO was full; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == BURST) && own_valid_s && full && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            full = 1'b0;
    logic [N-1:0]    req_ready;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      gnt_id;
    logic            busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        full      = 1'b0;
        req_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: whether a grant is held, by whom, words moved so far.
    bit m_busy;
    int m_own, m_gnt, m_words, m_next, m_stall;

    task automatic model_reset();
        m_busy = 1'b0; m_own = 0; m_gnt = 0; m_words = 0; m_next = 0; m_stall = 0;
    endtask

    task automatic model_check();
        logic [N-1:0] exp_ready;
        logic         exp_winc;
        exp_ready = '0;
        if (m_busy && !full) exp_ready[m_own] = 1'b1;
        exp_winc = m_busy && req_valid[m_own] && !full;
        check("rnd_busy", busy, m_busy);
        check("rnd_gnt", gnt_id, m_gnt);
        check("rnd_ready", req_ready, exp_ready);
        check("rnd_winc", winc, exp_winc);
        if (exp_winc) check("rnd_wdata", wdata, req_data[m_own*DW +: DW]);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("rnd_stall", stall_cnt, m_stall);
`endif
    endtask

    task automatic model_step();
        bit found;
        if (!m_busy) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!found && req_valid[(m_next + j) % N]) begin
                    found = 1'b1;
                    m_own = (m_next + j) % N;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_gnt = m_own; m_words = 0;
            end
        end else begin
            if (req_valid[m_own] && full && m_stall < 65535) m_stall++;
            if (req_valid[m_own] && !full) begin
                m_words++;
                if (req_last[m_own] || m_words == MB) begin
                    m_busy = 1'b0;
                    m_next = (m_own + 1) % N;
                end
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic         exp_busy;
        logic [1:0]   exp_gnt;
        logic         exp_winc;
        logic [N-1:0] exp_ready;
        logic [DW-1:0] exp_wdata;
    } vec_t;

    vec_t tbl[9];
    int   widx;
    int   wr_cnt;

    initial begin
        // Cycle-by-cycle vectors from reset; requester i presents constant data.
        tbl[0] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hB1};
        tbl[2] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 8'hB1};
        tbl[3] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 8'h00};
        tbl[4] = '{4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000, 8'h00};
        tbl[5] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000, 8'h00};
        tbl[6] = '{4'b1001, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hD3};
        tbl[7] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00};
        tbl[8] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0};

        // Reset state.
        @(negedge clk); #1;
        check("reset_busy", busy, 1'b0);
        check("reset_winc", winc, 1'b0);
        check("reset_ready", req_ready, 4'b0000);
        check("reset_gnt", gnt_id, 2'd0);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("reset_stall", stall_cnt, 16'd0);
`endif
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            full      = tbl[i].full;
            req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
            #1;
            check("tbl_busy", busy, tbl[i].exp_busy);
            check("tbl_gnt", gnt_id, tbl[i].exp_gnt);
            check("tbl_winc", winc, tbl[i].exp_winc);
            check("tbl_ready", req_ready, tbl[i].exp_ready);
            if (tbl[i].exp_winc) check("tbl_wdata", wdata, tbl[i].exp_wdata);
        end

        // Reset mid-burst with owner 2, then restart from pointer 0.
        do_reset();
        @(negedge clk); req_valid = 4'b0100;
        @(negedge clk); #1;
        check("midrst_pre_gnt", gnt_id, 2'd2);
        check("midrst_pre_busy", busy, 1'b1);
        rst_n = 1'b0; #1;
        check("midrst_winc", winc, 1'b0);
        check("midrst_ready", req_ready, 4'b0000);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1; req_valid = 4'b1100;
        @(negedge clk); #1;
        check("midrst_regrant", gnt_id, 2'd2);
        check("midrst_regrant_busy", busy, 1'b1);

        // Single requester streams 6 words with no last: 4, bubble, 2.
        do_reset();
        widx = 0; wr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            logic [7:0] pat;
            pat = 8'b1101_1110;
            @(negedge clk);
            req_valid = 4'b0010;
            req_data  = '0;
            req_data[DW +: DW] = 8'(widx);
            #1;
            check("single_winc", winc, pat[c]);
            if (winc) wr_cnt++;
            if (pat[c]) begin
                check("single_wdata", wdata, 8'(widx));
                check("single_gnt", gnt_id, 2'd1);
                widx++;
            end
        end
        check("single_count", wr_cnt, 6);

        // All four streaming: 16 words in 20 cycles, 4 per grant in order.
        do_reset();
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
            #1;
            if (winc) begin
                check("rr_gnt", gnt_id, wr_cnt / 4);
                wr_cnt++;
            end
        end
        check("rr_count", wr_cnt, 16);

        // Full back-pressure for 5 cycles mid-burst.
        do_reset();
        widx = 0;
        for (int c = 0; c < 11; c++) begin
            bit stalled, wr;
            stalled = (c >= 3 && c <= 7);
            wr      = (c >= 1 && c <= 2) || (c >= 8 && c <= 9);
            @(negedge clk);
            req_valid = 4'b0001;
            full      = stalled;
            req_data  = '0;
            req_data[0 +: DW] = 8'(widx);
            #1;
            check("full_winc", winc, wr);
            if (stalled) check("full_ready", req_ready, 4'b0000);
            if (c >= 1 && c <= 9) check("full_busy", busy, 1'b1);
            if (wr) begin
                check("full_wdata", wdata, 8'(widx));
                widx++;
            end
        end
        check("full_end_busy", busy, 1'b0);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("full_stall_cnt", stall_cnt, 16'd5);
`endif
        full = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                req_valid[b] = ($urandom_range(0, 9) < 7);
                req_last[b]  = ($urandom_range(0, 9) < 3);
            end
            full     = ($urandom_range(0, 4) == 0);
            req_data = $urandom;
            #1;
            model_check();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
